// File: rtl/game_controller.sv
// Tic-tac-toe turn sequencer: clears the board, then alternates X/O moves.
// Optional build macro GAME_CONTROLLER_AUTO_RESTART_EN lets a move strobe in END restart the game.
//
// Ports:
//   ph1            - clock, rising edge
//   reset          - synchronous active-high reset
//   isPlayer1Start - 1: PLAYER1 (X) moves first, 0: PLAYER2 (O) moves first
//   playerWrite    - one-cycle move request strobe
//   playerInput    - requested cell address
//   gameIsDone     - win/draw flag from the external checker
//   addr           - board cell address
//   cellState      - cell value to write (EMPTY=00, X=10, O=11)
//   cellWrite      - board write enable
//   outputState    - current FSM state code
module game_controller #(
    parameter int NUM_CELLS = 9
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic       isPlayer1Start,
    input  logic       playerWrite,
    input  logic [3:0] playerInput,
    input  logic       gameIsDone,
    output logic [3:0] addr,
    output logic [1:0] cellState,
    output logic       cellWrite,
    output logic [2:0] outputState
);

    typedef enum logic [2:0] {
        START   = 3'b000,
        PLAYER1 = 3'b001,
        PLAYER2 = 3'b010,
        END     = 3'b011
    } stateT;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] CELLX = 2'b10;
    localparam logic [1:0] CELLO = 2'b11;
    localparam logic [3:0] LAST_CELL = 4'(NUM_CELLS - 1);

    stateT      state;
    stateT      stateNext;
    logic [3:0] clearCount;
    logic [3:0] clearCountNext;
    logic       moveOk;

    // A move lands only when requested, on the board, and the game is live.
    assign moveOk = playerWrite && !gameIsDone && (playerInput <= LAST_CELL);

    always_ff @(posedge ph1) begin
        if (reset) begin
            state      <= START;
            clearCount <= '0;
        end else begin
            state      <= stateNext;
            clearCount <= clearCountNext;
        end
    end

    always_comb begin
        stateNext      = state;
        clearCountNext = '0;
        addr           = '0;
        cellState      = EMPTY;
        cellWrite      = 1'b0;
        case (state)
            START: begin
                addr      = clearCount;
                cellState = EMPTY;
                cellWrite = 1'b1;
                if (clearCount == LAST_CELL) begin
                    clearCountNext = '0;
                    stateNext      = isPlayer1Start ? PLAYER1 : PLAYER2;
                end else begin
                    clearCountNext = clearCount + 4'd1;
                end
            end
            PLAYER1: begin
                addr      = playerInput;
                cellState = CELLX;
                cellWrite = moveOk;
                if (gameIsDone) begin
                    stateNext = END;
                end else if (moveOk) begin
                    stateNext = PLAYER2;
                end
            end
            PLAYER2: begin
                addr      = playerInput;
                cellState = CELLO;
                cellWrite = moveOk;
                if (gameIsDone) begin
                    stateNext = END;
                end else if (moveOk) begin
                    stateNext = PLAYER1;
                end
            end
            END: begin
`ifdef GAME_CONTROLLER_AUTO_RESTART_EN
                if (playerWrite) begin
                    stateNext = START;
                end
`else
                stateNext = END;
`endif
            end
            default: begin
                // Unused encodings fall back to a fresh game.
                stateNext = START;
            end
        endcase
    end

    assign outputState = state;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller.
// Covers reset sweep, move alternation, invalid moves, game over and END handling.
module tb_game_controller;

    logic       ph1;
    logic       reset;
    logic       isPlayer1Start;
    logic       playerWrite;
    logic [3:0] playerInput;
    logic       gameIsDone;
    logic [3:0] addr;
    logic [1:0] cellState;
    logic       cellWrite;
    logic [2:0] outputState;

    int compared;
    int mismatched;

    game_controller #(.NUM_CELLS(9)) dut (
        .ph1(ph1),
        .reset(reset),
        .isPlayer1Start(isPlayer1Start),
        .playerWrite(playerWrite),
        .playerInput(playerInput),
        .gameIsDone(gameIsDone),
        .addr(addr),
        .cellState(cellState),
        .cellWrite(cellWrite),
        .outputState(outputState)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge ph1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        isPlayer1Start = 1'b1;
        step();
        reset = 1'b0;
        #2;
        compared++;
        if (outputState !== 3'b000 || addr !== 4'd0 ||
            cellState !== 2'b00 || cellWrite !== 1'b1) begin
            mismatched++;
            $display("FAIL reset: state=%b addr=%0d cell=%b wr=%b want 000 0 00 1",
                     outputState, addr, cellState, cellWrite);
        end
        for (int i = 0; i < 9; i++) begin
            compared++;
            if (outputState !== 3'b000 || addr !== 4'(i) ||
                cellState !== 2'b00 || cellWrite !== 1'b1) begin
                mismatched++;
                $display("FAIL sweep[%0d]: state=%b addr=%0d cell=%b wr=%b want 000 %0d 00 1",
                         i, outputState, addr, cellState, cellWrite, i);
            end
            step();
        end
        compared++;
        if (outputState !== 3'b001) begin
            mismatched++;
            $display("FAIL p1_start: state=%b want 001", outputState);
        end
    endtask

    task automatic test_alternate();
        playerWrite = 1'b1;
        playerInput = 4'd4;
        #2;
        compared++;
        if (addr !== 4'b0100 || cellState !== 2'b10 || cellWrite !== 1'b1) begin
            mismatched++;
            $display("FAIL move_x: addr=%b cell=%b wr=%b want 0100 10 1",
                     addr, cellState, cellWrite);
        end
        step();
        compared++;
        if (outputState !== 3'b010) begin
            mismatched++;
            $display("FAIL to_p2: state=%b want 010", outputState);
        end
        playerInput = 4'd0;
        #2;
        compared++;
        if (addr !== 4'd0 || cellState !== 2'b11 || cellWrite !== 1'b1) begin
            mismatched++;
            $display("FAIL move_o: addr=%b cell=%b wr=%b want 0000 11 1",
                     addr, cellState, cellWrite);
        end
        step();
        playerWrite = 1'b0;
        compared++;
        if (outputState !== 3'b001) begin
            mismatched++;
            $display("FAIL to_p1: state=%b want 001", outputState);
        end
    endtask

    task automatic test_idle_invalid();
        playerWrite = 1'b0;
        playerInput = 4'd3;
        #2;
        compared++;
        if (cellWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_wr: wr=%b want 0", cellWrite);
        end
        step();
        compared++;
        if (outputState !== 3'b001) begin
            mismatched++;
            $display("FAIL idle_hold: state=%b want 001", outputState);
        end
        playerWrite = 1'b1;
        playerInput = 4'b1011;
        #2;
        compared++;
        if (cellWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL bad11_wr: wr=%b want 0", cellWrite);
        end
        step();
        compared++;
        if (outputState !== 3'b001) begin
            mismatched++;
            $display("FAIL bad11_hold: state=%b want 001", outputState);
        end
        playerInput = 4'd9;
        #2;
        compared++;
        if (cellWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL bad9_wr: wr=%b want 0", cellWrite);
        end
        step();
        compared++;
        if (outputState !== 3'b001) begin
            mismatched++;
            $display("FAIL bad9_hold: state=%b want 001", outputState);
        end
        playerInput = 4'd8;
        #2;
        compared++;
        if (cellWrite !== 1'b1 || addr !== 4'd8 || cellState !== 2'b10) begin
            mismatched++;
            $display("FAIL edge8: addr=%0d cell=%b wr=%b want 8 10 1",
                     addr, cellState, cellWrite);
        end
        step();
        playerWrite = 1'b0;
        compared++;
        if (outputState !== 3'b010) begin
            mismatched++;
            $display("FAIL edge8_next: state=%b want 010", outputState);
        end
    endtask

    task automatic test_game_over();
        gameIsDone = 1'b1;
        playerWrite = 1'b1;
        playerInput = 4'd2;
        #2;
        compared++;
        if (cellWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL done_wr: wr=%b want 0", cellWrite);
        end
        step();
        gameIsDone = 1'b0;
        playerWrite = 1'b0;
        playerInput = 4'd7;
        #2;
        compared++;
        if (outputState !== 3'b011 || addr !== 4'd0 ||
            cellState !== 2'b00 || cellWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL end_out: state=%b addr=%b cell=%b wr=%b want 011 0000 00 0",
                     outputState, addr, cellState, cellWrite);
        end
        step();
        compared++;
        if (outputState !== 3'b011) begin
            mismatched++;
            $display("FAIL end_hold: state=%b want 011", outputState);
        end
    endtask

    task automatic test_end_restart();
        logic [2:0] expState;
`ifdef GAME_CONTROLLER_AUTO_RESTART_EN
        expState = 3'b000;
`else
        expState = 3'b011;
`endif
        playerWrite = 1'b1;
        playerInput = 4'd5;
        #2;
        compared++;
        if (cellWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL end_wr: wr=%b want 0", cellWrite);
        end
        step();
        playerWrite = 1'b0;
        compared++;
        if (outputState !== expState) begin
            mismatched++;
            $display("FAIL end_strobe: state=%b want %b", outputState, expState);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        isPlayer1Start = 1'b1;
        step();
        reset = 1'b0;
        // Only the last sweep cycle's value of isPlayer1Start matters.
        for (int i = 0; i < 9; i++) begin
            isPlayer1Start = (i == 8) ? 1'b0 : 1'b1;
            step();
        end
        compared++;
        if (outputState !== 3'b010) begin
            mismatched++;
            $display("FAIL p2_start: state=%b want 010", outputState);
        end
        reset = 1'b1;
        playerWrite = 1'b1;
        playerInput = 4'd6;
        step();
        reset = 1'b0;
        playerWrite = 1'b0;
        #2;
        compared++;
        if (outputState !== 3'b000 || addr !== 4'd0 || cellWrite !== 1'b1) begin
            mismatched++;
            $display("FAIL midreset: state=%b addr=%0d wr=%b want 000 0 1",
                     outputState, addr, cellWrite);
        end
        step();
        compared++;
        if (outputState !== 3'b000 || addr !== 4'd1) begin
            mismatched++;
            $display("FAIL midreset_next: state=%b addr=%0d want 000 1",
                     outputState, addr);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b0;
        isPlayer1Start = 1'b1;
        playerWrite = 1'b0;
        playerInput = 4'd0;
        gameIsDone = 1'b0;
        #1;
        test_reset();
        test_alternate();
        test_idle_invalid();
        test_game_over();
        test_end_restart();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
